// File: rtl/nios_key_poller.sv
// Avalon-MM read master that polls the keys PIO at a fixed rate, debounces each
// key and reports press/release pulses plus sticky press events with an irq.
module nios_key_poller #(
  parameter int WIDTH            = 4,
  parameter int POLL_CYCLES      = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int READ_LATENCY     = 1,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [WIDTH-1:0] event_pending,
  input  logic [WIDTH-1:0] event_clear,
  output logic             irq
);

  localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int CW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX      = CW'(DEBOUNCE_SAMPLES - 1);
  localparam logic [LW-1:0] LAT_LAST     = LW'(READ_LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic [LW-1:0]    lat_cnt;
  logic             tick;
  logic             capture;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] toggle;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  assign tick        = enable && (timer == '0);
  assign capture     = (state == WAIT) && (lat_cnt == LAT_LAST);
  assign avm_read    = (state == REQ);
  assign avm_address = 2'b00;
  assign irq         = |event_pending;
  assign sample      = (ACTIVE_LOW != 0) ? ~avm_readdata[WIDTH-1:0] : avm_readdata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_readdata;
      assign unused_readdata = ^avm_readdata[31:WIDTH];
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= TIMER_RELOAD;
    end else if (!enable || timer == '0) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - 1'b1;
    end
  end

  // An in-flight read always runs to completion; enable only gates new ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (tick) state <= REQ;
        REQ: begin
          state   <= WAIT;
          lat_cnt <= '0;
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) state <= IDLE;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default before the loop, so no
  // latch is inferred on the paths where capture is low.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (capture) begin
        if (sample[i] == key_state[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CNT_MAX) begin
          toggle[i]   = 1'b1;
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: the per-key counter array is small and must start at zero, so it is
  // reset like ordinary flops rather than left uninitialised like a RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      key_state     <= '0;
      key_press     <= '0;
      key_release   <= '0;
      event_pending <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      key_state     <= key_state ^ toggle;
      key_press     <= toggle & ~key_state;
      key_release   <= toggle & key_state;
      // A press pulse in the same cycle as a clear keeps the flag set.
      event_pending <= (event_pending & ~event_clear) | key_press;
    end
  end

endmodule

// File: tb/tb_nios_key_poller.sv
// Directed self-checking bench for nios_key_poller with a registered-readdata
// keys PIO model; outputs are sampled on the falling clock edge.
module tb_nios_key_poller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'h0000_000F;
  logic [3:0]  key_state;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic [3:0]  event_pending;
  logic [3:0]  event_clear = 4'h0;
  logic        irq;
  logic [3:0]  keys = 4'hF;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) avm_readdata <= {28'b0, keys};

  nios_key_poller #(
    .WIDTH(4), .POLL_CYCLES(8), .DEBOUNCE_SAMPLES(3), .READ_LATENCY(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .event_pending(event_pending), .event_clear(event_clear), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land mid-cycle on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at "cycle 0": the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {key_state, key_press, key_release, event_pending, irq, avm_read}, 32'h0);
  endtask

  logic [3:0] bounce_seq [6] = '{4'hE, 4'hF, 4'hE, 4'hE, 4'hF, 4'hE};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: idle keys, read cadence
    keys = 4'hF;
    enable = 1'b1;
    do_reset();
    check_quiet("t1_reset");
    for (int c = 1; c <= 26; c++) begin
      step();
      check($sformatf("t1_read_c%0d", c), avm_read, (c % 8 == 0));
      check($sformatf("t1_addr_c%0d", c), avm_address, 2'b00);
    end
    check("t1_state", {key_state, key_press, key_release, event_pending, irq}, 0);

    // 2: key 0 held from cycle 0 -> press on the third capture
    keys = 4'hE;
    do_reset();
    for (int c = 1; c <= 25; c++) step();
    check("t2_state_c25", key_state, 4'h0);
    step();
    check("t2_state_c26", key_state, 4'h1);
    check("t2_press_c26", key_press, 4'h1);
    check("t2_release_c26", key_release, 4'h0);
    step();
    check("t2_press_c27", key_press, 4'h0);
    check("t2_pending_c27", event_pending, 4'h1);
    check("t2_irq_c27", irq, 1'b1);

    // 4: release after three polls, clear, clear colliding with a new press
    keys = 4'hF;
    for (int c = 28; c <= 49; c++) step();
    check("t4_state_c49", key_state, 4'h1);
    step();
    check("t4_release_c50", key_release, 4'h1);
    check("t4_state_c50", key_state, 4'h0);
    check("t4_press_c50", key_press, 4'h0);
    step();
    check("t4_release_c51", key_release, 4'h0);
    check("t4_pending_c51", event_pending, 4'h1);
    step();
    event_clear = 4'hF;
    keys = 4'hE;
    step();
    event_clear = 4'h0;
    check("t4_pending_cleared", event_pending, 4'h0);
    check("t4_irq_cleared", irq, 1'b0);
    for (int c = 54; c <= 73; c++) step();
    check("t4_state_c73", key_state, 4'h0);
    step();
    check("t4_press_c74", key_press, 4'h1);
    event_clear = 4'h1;
    step();
    event_clear = 4'h0;
    check("t4_set_wins_pending", event_pending, 4'h1);
    check("t4_set_wins_irq", irq, 1'b1);
    event_clear = 4'h1;
    step();
    event_clear = 4'h0;
    check("t4_pending_final", event_pending, 4'h0);

    // 3: bouncing key 0 never reaches three consecutive pressed samples
    keys = 4'hF;
    do_reset();
    for (int c = 1; c <= 52; c++) begin
      step();
      if (c % 8 == 4) keys = bounce_seq[c / 8];
      check($sformatf("t3_bounce_c%0d", c), {key_state, key_press, key_release}, 12'h0);
    end

    // 5: enable dropped during REQ; that read still completes
    keys = 4'hE;
    enable = 1'b1;
    do_reset();
    for (int c = 1; c <= 23; c++) step();
    step();
    check("t5_read_c24", avm_read, 1'b1);
    enable = 1'b0;
    step();
    check("t5_read_c25", avm_read, 1'b0);
    step();
    check("t5_capture_state", key_state, 4'h1);
    check("t5_capture_press", key_press, 4'h1);
    for (int c = 27; c <= 66; c++) begin
      step();
      check($sformatf("t5_noread_c%0d", c), avm_read, 1'b0);
    end
    enable = 1'b1;
    for (int c = 67; c <= 74; c++) begin
      step();
      check($sformatf("t5_reenable_c%0d", c), avm_read, (c == 74));
    end

    // 6: asynchronous reset during WAIT
    keys = 4'hC;
    do_reset();
    for (int c = 1; c <= 33; c++) step();
    check("t6_state_pre", key_state, 4'h3);
    check("t6_pending_pre", event_pending, 4'h3);
    check("t6_irq_pre", irq, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_outputs", {key_state, key_press, key_release, event_pending, irq, avm_read}, 32'h0);
    keys = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("t6_read_c%0d", c), avm_read, (c == 8));
    end
    check("t6_state_post", key_state, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
